// File: rtl/vga_pkg.sv
// Shared VGA timing constants and capture state encoding.
// Used by both the VGA controller and the frame capture block.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_TOTAL  = 525;

    localparam int FB_DEPTH  = VGA_H_ACTIVE * VGA_V_ACTIVE;
    localparam int FB_ADDR_W = 19;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE
    } cap_state_t;

endpackage

// File: rtl/vga_sync_checker.sv
// Sampled sync edge detector with a period counter and length check.
// One instance per axis; the vertical one counts horizontal edges.
module vga_sync_checker #(
    parameter int TOTAL      = 800,
    parameter int CW         = 10,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic en,
    input  logic sync,
    input  logic inc,
    output logic edge_det,
    output logic mismatch
);

    logic          sync_q;
    logic          seen;
    logic [CW-1:0] cnt;
    logic          act;
    logic          act_q;
    logic [CW:0]   len;

    assign act      = sync ^ ACTIVE_LOW;
    assign act_q    = sync_q ^ ACTIVE_LOW;
    assign edge_det = pix_en & act & ~act_q;

    // an event landing on the edge strobe belongs to the period it closes
    assign len      = {1'b0, cnt} + {{CW{1'b0}}, inc};
    assign mismatch = edge_det & en & seen & (len != (CW + 1)'(TOTAL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= !ACTIVE_LOW;
            seen   <= 1'b0;
            cnt    <= '0;
        end else if (pix_en) begin
            sync_q <= sync;
            if (!en) begin
                seen <= 1'b0;
                cnt  <= '0;
            end else if (edge_det) begin
                seen <= 1'b1;
                cnt  <= '0;
            end else if (inc && cnt != '1) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_frame_capture.sv
// VGA pixel-stream receiver: checks line/frame timing and writes
// active pixels into a byte-wide framebuffer port.
module vga_frame_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = VGA_H_ACTIVE,
    parameter int H_TOTAL         = VGA_H_TOTAL,
    parameter int V_ACTIVE        = VGA_V_ACTIVE,
    parameter int V_TOTAL         = VGA_V_TOTAL,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    input  logic                 h_sync,
    input  logic                 v_sync,
    input  logic                 blank_n,
    input  logic [7:0]           rgb,
    output logic                 wr_en,
    output logic [FB_ADDR_W-1:0] wr_addr,
    output logic [7:0]           wr_data,
    output logic                 frame_done,
    output logic                 locked,
    output logic                 h_err,
    output logic                 v_err,
    output logic [15:0]          frame_count
);

    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam logic [FB_ADDR_W-1:0] DEPTH_A = FB_ADDR_W'(H_ACTIVE * V_ACTIVE);

    cap_state_t           state;
    logic [FB_ADDR_W-1:0] pix_cnt;
    logic                 pix_ovf;
    logic                 frame_bad;
    logic                 chk_en;
    logic                 h_edge;
    logic                 h_mis;
    logic                 v_edge;
    logic                 v_mis;
    logic                 frame_ok;
    logic                 cnt_bad;

    assign chk_en = (state != IDLE);

    vga_sync_checker #(
        .TOTAL      (H_TOTAL),
        .CW         (HW),
        .ACTIVE_LOW (SYNC_ACTIVE_LOW)
    ) u_hchk (
        .clk      (clk),
        .rst      (rst),
        .pix_en   (pix_en),
        .en       (chk_en),
        .sync     (h_sync),
        .inc      (1'b1),
        .edge_det (h_edge),
        .mismatch (h_mis)
    );

    vga_sync_checker #(
        .TOTAL      (V_TOTAL),
        .CW         (VW),
        .ACTIVE_LOW (SYNC_ACTIVE_LOW)
    ) u_vchk (
        .clk      (clk),
        .rst      (rst),
        .pix_en   (pix_en),
        .en       (chk_en),
        .sync     (v_sync),
        .inc      (h_edge),
        .edge_det (v_edge),
        .mismatch (v_mis)
    );

    // the checks made on the closing strobe still belong to this frame
    assign cnt_bad  = v_mis | pix_ovf | (pix_cnt != DEPTH_A);
    assign frame_ok = ~cnt_bad & ~frame_bad & ~h_mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            pix_ovf     <= 1'b0;
            frame_bad   <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            locked      <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            frame_count <= '0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (h_mis) h_err <= 1'b1;
            if (v_mis) v_err <= 1'b1;
            unique case (state)
                IDLE: state <= WAIT_VS;
                WAIT_VS: begin
                    if (v_edge) begin
                        state     <= CAPTURE;
                        pix_cnt   <= '0;
                        pix_ovf   <= 1'b0;
                        frame_bad <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (v_edge) begin
                        if (frame_ok) begin
                            frame_done  <= 1'b1;
                            locked      <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            locked <= 1'b0;
                            if (cnt_bad) v_err <= 1'b1;
                        end
                        pix_cnt   <= '0;
                        pix_ovf   <= 1'b0;
                        frame_bad <= 1'b0;
                    end else begin
                        if (h_mis) frame_bad <= 1'b1;
                        if (pix_en && blank_n) begin
                            if (pix_cnt < DEPTH_A) begin
                                wr_en   <= 1'b1;
                                wr_addr <= pix_cnt;
                                wr_data <= rgb;
                                pix_cnt <= pix_cnt + FB_ADDR_W'(1);
                            end else begin
                                pix_ovf <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a reduced raster (64x12 in 80x15),
// with an active-high-sync twin fed the same stream.
module tb_vga_frame_capture;

    localparam int HA    = 64;
    localparam int HT    = 80;
    localparam int VA    = 12;
    localparam int VT    = 15;
    localparam int DEPTH = HA * VA;
    localparam int HS0   = HA + 4;
    localparam int HS1   = HA + 12;
    localparam int VS0   = VA + 1;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        pix_en  = 1'b0;
    logic        hs_n    = 1'b1;
    logic        vs_n    = 1'b1;
    logic        hs_p    = 1'b0;
    logic        vs_p    = 1'b0;
    logic        blank_n = 1'b0;
    logic [7:0]  rgb     = '0;

    logic        wr_en, wr_en_p;
    logic [18:0] wr_addr, wr_addr_p;
    logic [7:0]  wr_data, wr_data_p;
    logic        frame_done, frame_done_p;
    logic        locked, locked_p;
    logic        h_err, h_err_p;
    logic        v_err, v_err_p;
    logic [15:0] frame_count, frame_count_p;

    vga_frame_capture #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_sync(hs_n), .v_sync(vs_n), .blank_n(blank_n), .rgb(rgb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .locked(locked),
        .h_err(h_err), .v_err(v_err), .frame_count(frame_count)
    );

    vga_frame_capture #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
        .SYNC_ACTIVE_LOW(1'b0)
    ) dut_p (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_sync(hs_p), .v_sync(vs_p), .blank_n(blank_n), .rgb(rgb),
        .wr_en(wr_en_p), .wr_addr(wr_addr_p), .wr_data(wr_data_p),
        .frame_done(frame_done_p), .locked(locked_p),
        .h_err(h_err_p), .v_err(v_err_p), .frame_count(frame_count_p)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    bit          stall = 1'b0;
    bit          capturing = 1'b0;
    bit          fbad = 1'b0;
    int          fpix = 0;
    int          exp_cnt = 0;
    int          exp_done = 0;
    bit          exp_locked = 1'b0;
    bit          exp_herr = 1'b0;
    bit          exp_verr = 1'b0;
    int          n_done = 0;
    int          n_done_p = 0;
    logic [18:0] max_addr = '0;
    logic [26:0] q_exp[$];
    logic [26:0] q_act[$];
    logic [26:0] q_actp[$];

    task automatic chk(input string tag, input longint got, input longint want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            q_act.push_back({wr_addr, wr_data});
            if (wr_addr > max_addr) max_addr = wr_addr;
        end
        if (wr_en_p === 1'b1) begin
            q_actp.push_back({wr_addr_p, wr_data_p});
            if (wr_addr_p > max_addr) max_addr = wr_addr_p;
        end
        if (frame_done === 1'b1) n_done++;
        if (frame_done_p === 1'b1) n_done_p++;
    end

    task automatic cmp_writes(input string tag);
        int bad;
        int badp;
        bad  = 0;
        badp = 0;
        chk({tag, "_nwr"}, q_act.size(), q_exp.size());
        chk({tag, "_nwr_p"}, q_actp.size(), q_exp.size());
        for (int i = 0; i < q_exp.size(); i++) begin
            if (i >= q_act.size() || q_act[i] != q_exp[i]) bad++;
            if (i >= q_actp.size() || q_actp[i] != q_exp[i]) badp++;
        end
        chk({tag, "_wr_bad"}, bad, 0);
        chk({tag, "_wr_bad_p"}, badp, 0);
        q_exp.delete();
        q_act.delete();
        q_actp.delete();
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_rst_outs"},
            {wr_en, wr_addr, wr_data, frame_done, locked, h_err, v_err, frame_count}, 0);
        chk({tag, "_rst_outs_p"},
            {wr_en_p, wr_addr_p, wr_data_p, frame_done_p, locked_p,
             h_err_p, v_err_p, frame_count_p}, 0);
        pix_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        capturing  = 1'b0;
        fbad       = 1'b0;
        fpix       = 0;
        exp_cnt    = 0;
        exp_done   = 0;
        exp_locked = 1'b0;
        exp_herr   = 1'b0;
        exp_verr   = 1'b0;
        n_done     = 0;
        n_done_p   = 0;
        max_addr   = '0;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        cmp_writes("pre_rst");
        apply_reset("mid");
    endtask

    task automatic strobe(input bit h, input bit v, input bit b, input logic [7:0] d);
        if (stall) begin
            pix_en = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        hs_n    = ~h;
        hs_p    = h;
        vs_n    = ~v;
        vs_p    = v;
        blank_n = b;
        rgb     = d;
        pix_en  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic edge_checks(input bit clean);
        chk("fdone", frame_done, clean);
        chk("fdone_p", frame_done_p, clean);
        chk("lock", locked, exp_locked);
        chk("lock_p", locked_p, exp_locked);
        chk("fcnt", frame_count, exp_cnt);
        chk("fcnt_p", frame_count_p, exp_cnt);
        chk("herr", h_err, exp_herr);
        chk("herr_p", h_err_p, exp_herr);
        chk("verr", v_err, exp_verr);
        chk("verr_p", v_err_p, exp_verr);
    endtask

    // one raster frame: lines 0..VA-1 active, v_sync on lines VS0..VS0+1
    task automatic drive_frame(input int short_ln, input int extra_ln,
                               input int rst_ln, input bit rnd);
        for (int l = 0; l < VT; l++) begin
            int len;
            len = (l == short_ln) ? HT - 1 : HT;
            if (l == short_ln) begin
                fbad     = 1'b1;
                exp_herr = 1'b1;
            end
            for (int x = 0; x < len; x++) begin
                bit         act;
                bit         ve;
                bit         clean;
                logic [7:0] d;
                if (l == rst_ln && x == 20) mid_reset();
                act = (l < VA) && (x < HA + ((l == extra_ln) ? 1 : 0));
                ve  = (l == VS0) && (x == 0);
                d   = rnd ? 8'($urandom) : 8'(l * HA + x);
                strobe(x >= HS0 && x < HS1, l >= VS0 && l < VS0 + 2, act, d);
                if (ve) begin
                    clean = capturing && fpix == DEPTH && !fbad;
                    if (capturing) begin
                        if (clean) begin
                            exp_cnt++;
                            exp_done++;
                            exp_locked = 1'b1;
                        end else begin
                            exp_locked = 1'b0;
                            if (fpix != DEPTH) exp_verr = 1'b1;
                        end
                    end
                    edge_checks(clean);
                    capturing = 1'b1;
                    fpix      = 0;
                    fbad      = 1'b0;
                end else if (act) begin
                    if (capturing && fpix < DEPTH) q_exp.push_back({19'(fpix), d});
                    fpix++;
                end
            end
        end
    endtask

    task automatic end_checks(input string tag);
        pix_en = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk({tag, "_locked"}, locked, exp_locked);
        chk({tag, "_locked_p"}, locked_p, exp_locked);
        chk({tag, "_count"}, frame_count, exp_cnt);
        chk({tag, "_count_p"}, frame_count_p, exp_cnt);
        chk({tag, "_h_err"}, h_err, exp_herr);
        chk({tag, "_h_err_p"}, h_err_p, exp_herr);
        chk({tag, "_v_err"}, v_err, exp_verr);
        chk({tag, "_v_err_p"}, v_err_p, exp_verr);
        chk({tag, "_ndone"}, n_done, exp_done);
        chk({tag, "_ndone_p"}, n_done_p, exp_done);
        chk({tag, "_addr_in_range"}, max_addr < DEPTH, 1);
    endtask

    initial begin
        apply_reset("nom");
        for (int f = 0; f < 3; f++) drive_frame(-1, -1, -1, 1'b0);
        end_checks("nom");
        if (q_act.size() > 641) begin
            chk("nom_a641_addr", q_act[641][26:8], 641);
            chk("nom_a641_data", q_act[641][7:0], 8'h81);
        end else begin
            chk("nom_a641_present", q_act.size(), 642);
        end
        cmp_writes("nom");

        apply_reset("short");
        drive_frame(-1, -1, -1, 1'b1);
        drive_frame(5, -1, -1, 1'b1);
        drive_frame(-1, -1, -1, 1'b1);
        end_checks("short");
        cmp_writes("short");

        apply_reset("extra");
        drive_frame(-1, -1, -1, 1'b1);
        drive_frame(-1, 3, -1, 1'b1);
        drive_frame(-1, -1, -1, 1'b1);
        end_checks("extra");
        cmp_writes("extra");

        apply_reset("stall");
        stall = 1'b1;
        for (int f = 0; f < 3; f++) drive_frame(-1, -1, -1, 1'b0);
        stall = 1'b0;
        end_checks("stall");
        cmp_writes("stall");

        apply_reset("rstmid");
        drive_frame(-1, -1, -1, 1'b1);
        drive_frame(-1, -1, -1, 1'b1);
        drive_frame(-1, -1, $urandom_range(2, VA - 2), 1'b1);
        drive_frame(-1, -1, -1, 1'b1);
        drive_frame(-1, -1, -1, 1'b1);
        end_checks("rstmid");
        if (q_act.size() > 0) chk("rstmid_first_addr", q_act[0][26:8], 0);
        else chk("rstmid_first_present", q_act.size(), 1);
        cmp_writes("rstmid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Pixel-stream receiver for the VGA output of the RSA ASIP system. It samples h_sync/v_sync/blank_n/rgb on each pixel strobe and checks line and frame lengths against 640x480@60 timing. Active pixels are written into a byte-wide framebuffer write port, so simulation benches and on-chip self-test can recover and compare displayed frames. It sits at the far end of the VGA link, beside the system under test, in the same clock domain as the VGA controller.

## Interface

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, pixel strobes per line (h_sync edge to h_sync edge)
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame (v_sync edge to v_sync edge)
- SYNC_ACTIVE_LOW, 1, sync polarity (1: assertion = falling edge)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- pix_en  in  1  one-clk-wide pixel strobe (the 25 MHz enable, synchronous to clk)
- h_sync  in  1  horizontal sync from controller
- v_sync  in  1  vertical sync from controller
- blank_n  in  1  high during active video
- rgb  in  8  pixel colour
- wr_en  out  1  framebuffer write strobe
- wr_addr  out  19  linear pixel address, y*H_ACTIVE + x
- wr_data  out  8  pixel value
- frame_done  out  1  one-clk pulse: a complete, clean frame has been written
- locked  out  1  last frame met all timing checks
- h_err  out  1  sticky: line length != H_TOTAL
- v_err  out  1  sticky: frame length != V_TOTAL, or pixel count != H_ACTIVE*V_ACTIVE
- frame_count  out  16  clean frames captured, wraps at 65535 -> 0

## Operation

- All inputs except pix_en are sampled only on clk edges where pix_en=1. Previous-sample registers (hs_q, vs_q) are used for edge detection.
- Sync assertion edge: hs_q inactive and h_sync active (polarity per SYNC_ACTIVE_LOW). The same rule applies to v_sync.
- h_cnt counts strobes since the last h_sync assertion edge. At each h_sync edge, h_cnt+1 != H_TOTAL sets h_err, except on the first edge after leaving IDLE. h_cnt then reloads to 0.
- v_cnt counts h_sync edges since the last v_sync edge. It is checked at each v_sync edge against V_TOTAL under the same first-edge exemption.
- State machine:
  - IDLE -> WAIT_VS once reset is released.
  - WAIT_VS -> CAPTURE on a v_sync edge. On that edge, pix_cnt is cleared and the error flags latched for the current frame are cleared (sticky outputs stay set).
  - CAPTURE: each strobe with blank_n=1 and pix_cnt < H_ACTIVE*V_ACTIVE writes rgb to wr_addr=pix_cnt, then pix_cnt increments. Active pixels beyond 307199 are dropped and mark the frame bad.
  - CAPTURE on a v_sync edge: the frame is clean if pix_cnt == 307200 and no length check in the frame failed.
    - Clean frame: pulse frame_done, set locked, increment frame_count.
    - Bad frame: clear locked, set v_err if a count mismatched.
    - Either way, restart the frame (pix_cnt=0) and stay in CAPTURE.
- h_err and v_err clear only on rst.
- A v_sync edge coinciding with an active pixel: the pixel is dropped, and the edge is processed first.

## Timing

- All registers are reset asynchronously by rst. Every output resets to 0 and the state resets to IDLE.
- Write latency is one clk. wr_en/wr_addr/wr_data are valid in the cycle after the clk edge that sampled the qualifying pix_en. wr_en is high for exactly one clk per pixel. wr_addr/wr_data hold their last values when wr_en=0.
- frame_done and the locked/frame_count updates are registered one clk after the sampling edge of the v_sync edge.
- Throughput is one pixel per clk, so pix_en may be held high continuously.
- rst mid-frame aborts the frame without a frame_done pulse. The next capture begins only at a fresh v_sync edge.

## Structure

- Package vga_pkg holds the timing constants (640/800/480/525), the FB_DEPTH = 307200 and FB_ADDR_W = 19 constants, and the capture state enum typedef (IDLE, WAIT_VS, CAPTURE). These are shared with the VGA controller.
- Sub-module vga_sync_checker, instantiated twice (horizontal and vertical): sampled-sync edge detector, length counter and mismatch flag, parameterised by TOTAL and counter width.

## Test plan

- Nominal: model controller drives 3 frames of 800x525 timing with rgb = pixel index[7:0]. Required: 307200 writes per frame, the write at addr 641 carries data 8'h81, frame_done pulses at the 2nd and 3rd v_sync edges, frame_count=2, locked=1, and h_err/v_err stay 0.
- Short line: line 100 is 799 strobes long. Required: h_err=1 and locked=0 at the next v_sync edge, no frame_done for that frame, and the following clean frame sets locked=1 while h_err stays 1.
- Extra active pixel: blank_n is held high for 641 strobes on one line. Required: frame flagged bad with v_err=1, no frame_done, and no write with wr_addr > 307199.
- Continuous pix_en=1 with stalls: pix_en toggles with random gaps. Required: identical captured data and frame_count to the nominal scenario.
- Reset mid-frame: rst is pulsed at line 200. Required: all outputs 0 within the same clk, no frame_done, and capture resumes with addr 0 after the next v_sync edge.
- Polarity: SYNC_ACTIVE_LOW=0 with inverted syncs. Required: same result as the nominal scenario.
